// File: rtl/bus_pkg.sv
// Shared data-bus request/response types for bus responders on the core's
// data bus. addr is a word address; mask selects byte lanes on writes.
package bus;

  typedef struct packed {
    logic        en;
    logic        we;
    logic [29:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } m2s_s;

  typedef struct packed {
    logic [31:0] data;
    logic        valid;
    logic        stall;
    logic        err;
  } s2m_s;

endpackage

// File: rtl/jpu_pkg.sv
// Core-level constants and helpers shared by peripherals: timer register
// offsets, the timer CTRL layout and the byte-lane write merge.
package jpu;

  localparam logic [3:0] TMR_MTIME_LO    = 4'd0;
  localparam logic [3:0] TMR_MTIME_HI    = 4'd1;
  localparam logic [3:0] TMR_MTIMECMP_LO = 4'd2;
  localparam logic [3:0] TMR_MTIMECMP_HI = 4'd3;
  localparam logic [3:0] TMR_CTRL        = 4'd4;
  localparam logic [3:0] TMR_STATUS      = 4'd5;
  localparam int         TMR_NUM_REGS    = 6;

  // Laid out exactly as the CTRL word so it can be cast to/from the bus.
  // rsvd is held at zero; prescale bits above the configured width are too.
  typedef struct packed {
    logic [23:0] prescale;
    logic [5:0]  rsvd;
    logic        irq_en;
    logic        run;
  } tmr_ctrl_s;

  // Byte lanes with a 0 mask bit keep the old contents.
  function automatic logic [31:0] apply_byte_mask(input logic [31:0] old_word,
                                                  input logic [31:0] new_word,
                                                  input logic [3:0]  mask);
    logic [31:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/bus_slave_port.sv
// Generic bus responder front end: decodes a 16-word window, flags reserved
// offsets, and registers a one-cycle response. The owning peripheral supplies
// combinational read data for the current offset and acts on req_rd/req_wr.
module bus_slave_port
  import bus::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int          NUM_REGS  = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  m2s_s        bus_in,
  output s2m_s        bus_out,
  output logic        req_rd,
  output logic        req_wr,
  output logic [3:0]  req_off,
  output logic [31:0] req_wdata,
  output logic [3:0]  req_mask,
  input  logic [31:0] rdata
);

  logic sel;
  logic legal;

  assign sel   = bus_in.en & (bus_in.addr[29:4] == BASE_ADDR[31:6]);
  assign legal = ({28'd0, bus_in.addr[3:0]} < 32'(NUM_REGS));

  // Reserved offsets never reach the peripheral, so they cannot change state.
  assign req_rd    = sel & ~bus_in.we & legal;
  assign req_wr    = sel &  bus_in.we & legal;
  assign req_off   = bus_in.addr[3:0];
  assign req_wdata = bus_in.data;
  assign req_mask  = bus_in.mask;

  // One-cycle response: valid for every selected request, data only on reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_out <= '0;
    end else begin
      bus_out.valid <= sel;
      bus_out.err   <= sel & ~legal;
      bus_out.stall <= 1'b0;
      bus_out.data  <= req_rd ? rdata : 32'd0;
    end
  end

endmodule

// File: rtl/bus_timer.sv
// Memory-mapped machine timer: 64-bit free-running mtime with prescaler,
// 64-bit mtimecmp, registered level interrupt and sticky match flag.
// MTIME_HI reads a shadow captured by the preceding MTIME_LO read, so a
// LO-then-HI pair is always a consistent 64-bit sample.
`ifndef TIMER_BASE_ADDR
`define TIMER_BASE_ADDR 32'h0200_0000
`endif

module bus_timer
  import bus::*, jpu::*;
#(
  parameter logic [31:0] BASE_ADDR  = `TIMER_BASE_ADDR,
  parameter int          PRESCALE_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  m2s_s bus_in,
  output s2m_s bus_out,
  output logic timer_irq
);

  localparam logic [31:0] CTRL_WMASK =
    (((32'd1 << PRESCALE_W) - 32'd1) << 8) | 32'd3;

  logic                  req_rd;
  logic                  req_wr;
  logic [3:0]            req_off;
  logic [31:0]           req_wdata;
  logic [3:0]            req_mask;
  logic [31:0]           rdata;

  logic [63:0]           mtime_q;
  logic [63:0]           mtime_d;
  logic [63:0]           mtimecmp_q;
  logic [63:0]           mtimecmp_d;
  logic [31:0]           shadow_q;
  tmr_ctrl_s             ctrl_q;
  tmr_ctrl_s             ctrl_d;
  logic [PRESCALE_W-1:0] psc_cnt_q;
  logic [PRESCALE_W-1:0] psc_cnt_d;
  logic                  sticky_q;
  logic                  sticky_d;
  logic                  irq_q;

  logic wr_mtime_lo;
  logic wr_mtime_hi;
  logic wr_cmp_lo;
  logic wr_cmp_hi;
  logic wr_ctrl;
  logic wr_status;
  logic rd_mtime_lo;
  logic tick;
  logic cmp_ge;
  logic sticky_clr;

  bus_slave_port #(
    .BASE_ADDR (BASE_ADDR),
    .NUM_REGS  (TMR_NUM_REGS)
  ) u_port (
    .clk       (clk),
    .rst       (rst),
    .bus_in    (bus_in),
    .bus_out   (bus_out),
    .req_rd    (req_rd),
    .req_wr    (req_wr),
    .req_off   (req_off),
    .req_wdata (req_wdata),
    .req_mask  (req_mask),
    .rdata     (rdata)
  );

  assign wr_mtime_lo = req_wr & (req_off == TMR_MTIME_LO);
  assign wr_mtime_hi = req_wr & (req_off == TMR_MTIME_HI);
  assign wr_cmp_lo   = req_wr & (req_off == TMR_MTIMECMP_LO);
  assign wr_cmp_hi   = req_wr & (req_off == TMR_MTIMECMP_HI);
  assign wr_ctrl     = req_wr & (req_off == TMR_CTRL);
  assign wr_status   = req_wr & (req_off == TMR_STATUS);
  assign rd_mtime_lo = req_rd & (req_off == TMR_MTIME_LO);

  // A CTRL write restarts the prescale period, so it also swallows this
  // cycle's tick; otherwise the counter wraps at the programmed reload.
  assign tick       = ctrl_q.run & ~wr_ctrl &
                      (psc_cnt_q == ctrl_q.prescale[PRESCALE_W-1:0]);
  assign cmp_ge     = (mtime_q >= mtimecmp_q);
  assign sticky_clr = wr_status & req_mask[0] & req_wdata[1];
  assign timer_irq  = irq_q;

  // Read mux reflects register contents before this edge's updates.
  always_comb begin
    rdata = 32'd0;
    case (req_off)
      TMR_MTIME_LO:    rdata = mtime_q[31:0];
      TMR_MTIME_HI:    rdata = shadow_q;
      TMR_MTIMECMP_LO: rdata = mtimecmp_q[31:0];
      TMR_MTIMECMP_HI: rdata = mtimecmp_q[63:32];
      TMR_CTRL:        rdata = ctrl_q;
      TMR_STATUS:      rdata = {30'd0, sticky_q, irq_q};
      default:         rdata = 32'd0;
    endcase
  end

  // Next-state for counter, compare, control and status; a bus write to
  // either mtime word takes priority over the tick and blocks the carry.
  always_comb begin
    mtime_d    = mtime_q;
    mtimecmp_d = mtimecmp_q;
    ctrl_d     = ctrl_q;
    psc_cnt_d  = psc_cnt_q;

    if (wr_mtime_lo) begin
      mtime_d[31:0] = apply_byte_mask(mtime_q[31:0], req_wdata, req_mask);
    end else if (wr_mtime_hi) begin
      mtime_d[63:32] = apply_byte_mask(mtime_q[63:32], req_wdata, req_mask);
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end

    if (wr_cmp_lo) begin
      mtimecmp_d[31:0] = apply_byte_mask(mtimecmp_q[31:0], req_wdata, req_mask);
    end
    if (wr_cmp_hi) begin
      mtimecmp_d[63:32] = apply_byte_mask(mtimecmp_q[63:32], req_wdata, req_mask);
    end

    if (wr_ctrl) begin
      ctrl_d    = tmr_ctrl_s'(apply_byte_mask(ctrl_q, req_wdata, req_mask) & CTRL_WMASK);
      psc_cnt_d = '0;
    end else if (ctrl_q.run) begin
      psc_cnt_d = tick ? '0 : psc_cnt_q + PRESCALE_W'(1);
    end

    // A true compare outranks a same-cycle clear.
    sticky_d = cmp_ge | (sticky_q & ~sticky_clr);
  end

  // Timer state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtime_q    <= 64'd0;
      mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
      ctrl_q     <= '0;
      psc_cnt_q  <= '0;
      sticky_q   <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      ctrl_q     <= ctrl_d;
      psc_cnt_q  <= psc_cnt_d;
      sticky_q   <= sticky_d;
      irq_q      <= ctrl_q.irq_en & cmp_ge;
    end
  end

  // High-word shadow, refreshed only by a low-word read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q <= 32'd0;
    end else if (rd_mtime_lo) begin
      shadow_q <= mtime_q[63:32];
    end
  end

endmodule
